alu_cmd_sequencer: RTL and testbench

Command sequencer directly upstream of the registered ALU. Accepts one operation at a time (operands plus 3-bit opcode) over a valid/ready handshake. Drives the ALU operand, select and enable inputs for exactly one cycle, then captures the registered ALU result and flags. Presents the captured result downstream over a second valid/ready handshake, and keeps a saturating count of completed operations.

---
 rtl/alu_cmd_sequencer.sv | 119 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Sits directly upstream of the registered ALU. Takes one operation at a time
// (two operands plus a 3-bit opcode), drives the ALU inputs, pulses the ALU
// enable for a single cycle, captures the registered result and flags, and
// offers the captured result downstream. Keeps a saturating count of results
// that have been handed off.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer keeps valid and its payload steady until that edge;
// ready may change at any time and never depends combinationally on valid.
//
// Ports:
//   clk, arst           clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (cmd_a, cmd_b, cmd_select payload)
//   alu_a/b/select      operands and opcode driven to the ALU, held between ops
//   alu_enable          one-cycle strobe that makes the ALU register a result
//   alu_out, alu_carry_out, alu_greater/equal/less   ALU result and flags
//   res_valid/ready     result handshake
//   res_data, res_carry, res_div_by_zero, res_flags  captured result payload
//   op_count            number of completed result handshakes, saturating

module alu_cmd_sequencer #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [2:0]             cmd_select,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_select,
    output logic                   alu_enable,
    input  logic [2*WIDTH-1:0]     alu_out,
    input  logic                   alu_carry_out,
    input  logic                   alu_greater,
    input  logic                   alu_equal,
    input  logic                   alu_less,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*WIDTH-1:0]     res_data,
    output logic                   res_carry,
    output logic                   res_div_by_zero,
    output logic [2:0]             res_flags,
    output logic [CNT_WIDTH-1:0]   op_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [2:0]           OP_ADD  = 3'b000;
    localparam logic [2:0]           OP_DIV  = 3'b111;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic       div_by_zero;

    // Divide-by-zero is decided here from the held operands rather than
    // trusting whatever the ALU reports for that case.
    assign div_by_zero = (alu_select == OP_DIV) && (alu_b == '0);

    // Gated by arst so no command can be offered acceptance during reset.
    assign cmd_ready  = (state == ST_IDLE) && !arst;
    assign alu_enable = (state == ST_ISSUE);
    assign res_valid  = (state == ST_HOLD);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state           <= ST_IDLE;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_select      <= '0;
            res_data        <= '0;
            res_carry       <= 1'b0;
            res_div_by_zero <= 1'b0;
            res_flags       <= '0;
            op_count        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_select <= cmd_select;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // ALU registers its result on this edge.
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    res_data        <= div_by_zero ? '0 : alu_out;
                    res_carry       <= (alu_select == OP_ADD) ? alu_carry_out : 1'b0;
                    res_div_by_zero <= div_by_zero;
                    res_flags       <= {alu_greater, alu_equal, alu_less};
                    state           <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        if (op_count != CNT_MAX) begin
                            op_count <= op_count + CNT_ONE;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer. Includes a behavioural registered ALU so the
// sequencer has something real to drive, a timeline/result reference model,
// and a scoreboard fed at command acceptance and drained at result handoff.

module tb_alu_cmd_sequencer;

    localparam int W  = 4;
    localparam int CW = 3;   // small counter so saturation is reached

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    logic            cmd_valid, cmd_ready;
    logic [W-1:0]    cmd_a, cmd_b;
    logic [2:0]      cmd_select;
    logic [W-1:0]    alu_a, alu_b;
    logic [2:0]      alu_select;
    logic            alu_enable;
    logic [2*W-1:0]  alu_out;
    logic            alu_carry_out;
    logic            alu_greater, alu_equal, alu_less;
    logic            res_valid, res_ready;
    logic [2*W-1:0]  res_data;
    logic            res_carry, res_div_by_zero;
    logic [2:0]      res_flags;
    logic [CW-1:0]   op_count;

    alu_cmd_sequencer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_select(cmd_select),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_enable(alu_enable),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out),
        .alu_greater(alu_greater), .alu_equal(alu_equal), .alu_less(alu_less),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry),
        .res_div_by_zero(res_div_by_zero), .res_flags(res_flags),
        .op_count(op_count)
    );

    // ---------------- behavioural ALU ----------------
    // Registered result on enable; flags combinational. Carry and the
    // divide-by-zero result carry junk so the sequencer's masking matters.
    assign alu_greater = alu_a > alu_b;
    assign alu_equal   = alu_a == alu_b;
    assign alu_less    = alu_a < alu_b;

    always @(posedge clk) begin
        if (alu_enable) begin
            logic [W:0] s;
            s = {1'b0, alu_a} + {1'b0, alu_b};
            alu_carry_out <= 1'b1;
            case (alu_select)
                3'b000: begin alu_out <= {{W{1'b0}}, s[W-1:0]}; alu_carry_out <= s[W]; end
                3'b001: alu_out <= {{W{1'b0}}, alu_a - alu_b};
                3'b010: alu_out <= {{W{1'b0}}, alu_a & alu_b};
                3'b011: alu_out <= {{W{1'b0}}, alu_a | alu_b};
                3'b100: alu_out <= {{W{1'b0}}, alu_a ^ alu_b};
                3'b101: alu_out <= {{(2*W-1){1'b0}}, alu_a == alu_b};
                3'b110: alu_out <= {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};
                default: alu_out <= (alu_b == 0) ? {(2*W){1'b1}} : {{W{1'b0}}, alu_a / alu_b};
            endcase
        end
    end

    // ---------------- reference model ----------------
    // Result = {data, carry, div_by_zero, flags{gt,eq,lt}}.
    function automatic logic [2*W+4:0] ref_res(input int a, input int b, input int sel);
        int mask, d;
        logic c, z;
        logic [2:0] f;
        mask = (1 << W) - 1;
        c = 1'b0;
        z = 1'b0;
        f = {a > b, a == b, a < b};
        case (sel)
            0: begin d = (a + b) & mask; c = (a + b) > mask; end
            1: d = (a - b) & mask;
            2: d = a & b;
            3: d = a | b;
            4: d = a ^ b;
            5: d = (a == b) ? 1 : 0;
            6: d = a * b;
            default: begin
                if (b == 0) begin z = 1'b1; d = 0; end
                else d = a / b;
            end
        endcase
        return {d[2*W-1:0], c, z, f};
    endfunction

    // ---------------- scoreboard ----------------
    logic [2*W+4:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int phase = 0;              // 0 idle, 1 issue, 2 capture, 3 hold
    int model_cnt = 0;
    logic [2*W+2:0] last_cmd = '0;
    bit mon_on = 1'b0;
    int rdy_mode = 1;           // 0 random, 1 always ready, 2 never ready

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (arst) begin
                chk("reset_outputs",
                    {cmd_ready, alu_enable, res_valid, alu_a, alu_b, alu_select,
                     res_data, res_carry, res_div_by_zero, res_flags, op_count},
                    '0);
                phase = 0;
                exp_q.delete();
                model_cnt = 0;
                last_cmd = '0;
            end else begin
                chk("cmd_ready", cmd_ready, phase == 0);
                chk("alu_enable", alu_enable, phase == 1);
                chk("res_valid", res_valid, phase == 3);
                chk("alu_inputs", {alu_a, alu_b, alu_select}, last_cmd);
                case (phase)
                    0: if (cmd_valid) begin
                        exp_q.push_back(ref_res(cmd_a, cmd_b, cmd_select));
                        last_cmd = {cmd_a, cmd_b, cmd_select};
                        phase = 1;
                    end
                    1: phase = 2;
                    2: phase = 3;
                    default: begin
                        if (exp_q.size() == 0) begin
                            chk("sb_nonempty", 0, 1);
                        end else begin
                            chk("res_payload",
                                {res_data, res_carry, res_div_by_zero, res_flags}, exp_q[0]);
                            if (res_ready) begin
                                chk("op_count", op_count, model_cnt);
                                void'(exp_q.pop_front());
                                if (model_cnt < (1 << CW) - 1) model_cnt++;
                                phase = 0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: res_ready = ($urandom_range(0, 3) != 0);
                1: res_ready = 1'b1;
                default: res_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel);
        int n;
        @(posedge clk);
        #1;
        cmd_a = a;
        cmd_b = b;
        cmd_select = sel;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a = W'($urandom);
        cmd_b = W'($urandom);
        cmd_select = 3'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((phase != 0 || exp_q.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("drain_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_select = '0;
        repeat (2) @(posedge clk);

        // Reset asserted mid-cycle: outputs clear without waiting for an edge.
        #2 arst = 1'b1;
        #1;
        chk("reset_immediate",
            {cmd_ready, alu_enable, res_valid, alu_a, alu_b, alu_select,
             res_data, res_carry, res_div_by_zero, res_flags, op_count}, '0);
        mon_on = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 arst = 1'b0;

        // Directed operations.
        send(4'd9, 4'd8, 3'b000);    // 0x01, carry 1, flags 100
        wait_idle();
        send(4'd15, 4'd15, 3'b110);  // 0xE1, count 1 -> 2
        wait_idle();
        send(4'd7, 4'd0, 3'b111);    // div by zero
        wait_idle();

        // Backpressure with a competing command offered during HOLD.
        rdy_mode = 2;
        send(4'd3, 4'd5, 3'b001);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) chk("hold_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_a = 4'd12;
        cmd_b = 4'd10;
        cmd_select = 3'b100;
        cmd_valid = 1'b1;
        repeat (5) @(posedge clk);
        rdy_mode = 1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) chk("bp_accept_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_idle();

        // Reset during CAPTURE aborts the operation.
        send(4'd6, 4'd2, 3'b010);
        @(posedge clk);
        #2 arst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 arst = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("count_after_abort", op_count, 0);

        // Randomised traffic; runs the counter into saturation.
        rdy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] rb;
            rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            send(W'($urandom), rb, 3'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rdy_mode = 1;
        wait_idle();
        #1 chk("count_saturated", op_count, (1 << CW) - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
